request_issue_queue: RTL

Sixteen-entry request buffer on the consuming side of the scheduling-priority logic in the memory controller. It stores incoming requests and keeps a saturating age per entry. It exports per-entry `valid`/`age`/`unscheduled` fields to the priority scorer. It takes the sixteen 8-bit scores back, selects the highest-scoring valid entry, and issues it to the DRAM command stage over a valid/ready handshake, freeing that entry.

---
 rtl/mc_pkg.sv | 40 ++++
 rtl/sched_argmax16.sv | 37 +++
 rtl/request_issue_queue.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared memory-controller queue constants, request type and argmax helper
package mc_pkg;

    localparam int MC_DEPTH   = 16;
    localparam int MC_AGE_W   = 6;
    localparam int MC_SCORE_W = 8;
    localparam int MC_IDX_W   = 4;
    localparam int MC_ADDR_W  = 32;

    localparam logic [MC_AGE_W-1:0] MC_AGE_MAX = '1;

    typedef enum logic [1:0] {
        MC_CLASS_NORMAL   = 2'd0,
        MC_CLASS_ELEVATED = 2'd1,
        MC_CLASS_HIGH     = 2'd2,
        MC_CLASS_URGENT   = 2'd3
    } mc_class_e;

    typedef struct packed {
        logic [MC_ADDR_W-1:0] addr;
        mc_class_e            cls;
        logic                 wr;
    } mc_req_t;

    // One node of the score compare tree
    typedef struct packed {
        logic                  found;
        logic [MC_IDX_W-1:0]   idx;
        logic [MC_SCORE_W-1:0] score;
    } mc_node_t;

    // a is always the lower-index side, so >= gives the lowest-index tie-break
    function automatic mc_node_t mc_pick(input mc_node_t a, input mc_node_t b);
        if (a.found && (!b.found || a.score >= b.score)) begin
            return a;
        end
        return b;
    endfunction

endpackage

// File: rtl/sched_argmax16.sv
// rtl/sched_argmax16.sv - 16-input combinational score argmax, lowest index wins ties
module sched_argmax16
    import mc_pkg::*;
(
    input  logic [MC_DEPTH-1:0]            valid_i,
    input  logic [MC_DEPTH*MC_SCORE_W-1:0] score_i,
    output logic                           found_o,
    output logic [MC_IDX_W-1:0]            idx_o
);

    mc_node_t l0 [16];
    mc_node_t l1 [8];
    mc_node_t l2 [4];
    mc_node_t l3 [2];

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_leaf
            assign l0[gi] = '{found: valid_i[gi], idx: 4'(gi), score: score_i[8*gi +: 8]};
        end
        for (gi = 0; gi < 8; gi++) begin : g_lvl1
            assign l1[gi] = mc_pick(l0[2*gi], l0[2*gi+1]);
        end
        for (gi = 0; gi < 4; gi++) begin : g_lvl2
            assign l2[gi] = mc_pick(l1[2*gi], l1[2*gi+1]);
        end
        for (gi = 0; gi < 2; gi++) begin : g_lvl3
            assign l3[gi] = mc_pick(l2[2*gi], l2[2*gi+1]);
        end
    endgenerate

    // Root compare only needs the winner's presence and index
    assign found_o = l3[0].found | l3[1].found;
    assign idx_o   = (l3[0].found && (!l3[1].found || l3[0].score >= l3[1].score))
                     ? l3[0].idx : l3[1].idx;

endmodule

// File: rtl/request_issue_queue.sv
// rtl/request_issue_queue.sv - 16-entry aged request buffer with score-based issue slot (option: STARVATION_GUARD_EN)
module request_issue_queue
    import mc_pkg::*;
#(
    parameter int ADDR_W = MC_ADDR_W,   // must equal MC_ADDR_W, the stored request width
    parameter int DEPTH  = MC_DEPTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [ADDR_W-1:0]              req_addr,
    input  logic [1:0]                     req_class,
    input  logic                           req_wr,
    output logic [MC_DEPTH-1:0]            ent_valid,
    output logic [MC_DEPTH*MC_AGE_W-1:0]   ent_age,
    output logic [MC_DEPTH*3-1:0]          ent_unsched,
    input  logic [MC_DEPTH*MC_SCORE_W-1:0] sched_score,
    output logic                           iss_valid,
    input  logic                           iss_ready,
    output logic [ADDR_W-1:0]              iss_addr,
    output logic [1:0]                     iss_class,
    output logic                           iss_wr,
    output logic [MC_IDX_W-1:0]            iss_idx,
    output logic [4:0]                     count
);

    logic [MC_DEPTH-1:0] valid_q, valid_d;
    logic [MC_AGE_W-1:0] age_q [MC_DEPTH];
    logic [MC_AGE_W-1:0] age_d [MC_DEPTH];
    mc_req_t             ent_q [MC_DEPTH];
    mc_req_t             ent_d [MC_DEPTH];
    logic                iss_valid_q;
    mc_req_t             iss_q;
    logic [MC_IDX_W-1:0] iss_idx_q;
    logic [4:0]          count_q;

    logic                am_found;
    logic [MC_IDX_W-1:0] am_idx;
    logic [MC_IDX_W-1:0] sel_idx;
    logic [MC_IDX_W-1:0] free_idx;
    logic                push, slot_free, load;

    sched_argmax16 u_argmax (
        .valid_i (valid_q),
        .score_i (sched_score),
        .found_o (am_found),
        .idx_o   (am_idx)
    );

`ifdef STARVATION_GUARD_EN
    logic                sat_any;
    logic [MC_IDX_W-1:0] sat_idx;

    // Lowest-index valid entry whose age has saturated preempts the scorer
    always_comb begin
        sat_any = 1'b0;
        sat_idx = '0;
        for (int i = MC_DEPTH - 1; i >= 0; i--) begin
            if (valid_q[i] && age_q[i] == MC_AGE_MAX) begin
                sat_any = 1'b1;
                sat_idx = 4'(i);
            end
        end
    end

    assign sel_idx = sat_any ? sat_idx : am_idx;
`else
    assign sel_idx = am_idx;
`endif

    // Lowest free entry from registered occupancy, so a same-cycle pop is not reused
    always_comb begin
        free_idx = '0;
        for (int i = MC_DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_idx = 4'(i);
            end
        end
    end

    assign req_ready = (count_q != 5'(DEPTH));
    assign push      = req_valid && req_ready;
    assign slot_free = !iss_valid_q || iss_ready;
    assign load      = slot_free && am_found;

    // Entry array next state: age everything, then free the winner, then fill
    always_comb begin
        valid_d = valid_q;
        age_d   = age_q;
        ent_d   = ent_q;
        for (int i = 0; i < MC_DEPTH; i++) begin
            if (valid_q[i] && age_q[i] != MC_AGE_MAX) begin
                age_d[i] = age_q[i] + 6'd1;
            end
        end
        if (load) begin
            valid_d[sel_idx] = 1'b0;
            age_d[sel_idx]   = '0;
        end
        if (push) begin
            valid_d[free_idx] = 1'b1;
            age_d[free_idx]   = '0;
            ent_d[free_idx]   = '{addr: req_addr, cls: mc_class_e'(req_class), wr: req_wr};
        end
    end

    // Entry storage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < MC_DEPTH; i++) begin
                age_q[i] <= '0;
                ent_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            age_q   <= age_d;
            ent_q   <= ent_d;
        end
    end

    // Issue slot and occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_valid_q <= 1'b0;
            iss_q       <= '0;
            iss_idx_q   <= '0;
            count_q     <= '0;
        end else begin
            if (slot_free) begin
                iss_valid_q <= am_found;
                if (am_found) begin
                    iss_q     <= ent_q[sel_idx];
                    iss_idx_q <= sel_idx;
                end
            end
            count_q <= count_q + 5'(push) - 5'(load);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < MC_DEPTH; gi++) begin : g_pack
            assign ent_age[MC_AGE_W*gi +: MC_AGE_W] = age_q[gi];
            assign ent_unsched[3*gi +: 3]           = {ent_q[gi].cls, ent_q[gi].wr};
        end
    endgenerate

    assign ent_valid = valid_q;
    assign iss_valid = iss_valid_q;
    assign iss_addr  = iss_q.addr;
    assign iss_class = iss_q.cls;
    assign iss_wr    = iss_q.wr;
    assign iss_idx   = iss_idx_q;
    assign count     = count_q;

endmodule
